fp_add_share_ctrl: RTL and testbench
====================================

Name: fp_add_share_ctrl

Overview:
- Shares one fixed-latency, non-stalling FP32 add/sub pipeline (sign/align, add, normalise, exponent adjust) among NUM_REQ requesters.
- Round-robin arbitration; at most one operation in flight per requester (single credit).
- Tracks ownership with a tag pipeline matched to the adder latency.
- Routes each result plus flags into a per-requester one-entry result buffer drained by a valid/ready handshake.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADD_LAT, 3, cycles from o_add_valid to i_add_res_valid in the shared adder (>=1).
- TAG_W, $clog2(NUM_REQ), owner tag width (derived; not overridden).

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_req_valid  in  NUM_REQ  per-requester operation request.
- o_req_ready  out  NUM_REQ  one-hot grant; request accepted when valid&&ready.
- i_req_a  in  NUM_REQ*32  operand A per requester, FP32.
- i_req_b  in  NUM_REQ*32  operand B per requester, FP32.
- i_req_sub  in  NUM_REQ  1 = A-B, 0 = A+B.
- o_add_valid  out  1  issue strobe to shared adder.
- o_add_a  out  32  issued operand A.
- o_add_b  out  32  issued operand B.
- o_add_sub  out  1  issued op.
- i_add_res_valid  in  1  adder output strobe.
- i_add_result  in  32  adder result.
- i_add_flags  in  3  {overflow, underflow, zero}.
- o_res_valid  out  NUM_REQ  result buffer full.
- i_res_ready  in  NUM_REQ  requester consumes result.
- o_res_data  out  NUM_REQ*32  buffered result per requester.
- o_res_flags  out  NUM_REQ*3  buffered flags per requester.
- o_err  out  1  sticky protocol error.

Behaviour:
- Reset (async, i_rst_n=0):
  - o_add_valid, o_add_a/b/sub = 0.
  - o_res_valid, o_res_data, o_res_flags = 0.
  - o_err = 0.
  - All credits = 1; rr pointer = 0; tag pipeline cleared.
  - Any in-flight results are discarded. The shared adder is reset by the same i_rst_n.
- Eligibility: eligible[k] = i_req_valid[k] && credit[k].
- Arbitration (combinational):
  - o_req_ready = one-hot grant to the first eligible index at or after ptr, wrapping modulo NUM_REQ.
  - Nothing eligible -> o_req_ready = 0.
- Issue: on grant of k at cycle t:
  - At t+1, o_add_valid=1 with k's a/b/sub registered.
  - credit[k] clears at t+1; ptr becomes (k+1) mod NUM_REQ.
  - No grant -> o_add_valid=0 next cycle; operand regs hold their values.
- Throughput: one issue per cycle across requesters.
- Tag pipeline: shift register of {valid, tag}, ADD_LAT stages, loaded alongside o_add_valid.
  - Stage ADD_LAT is compared with i_add_res_valid.
  - Mismatch in either direction sets o_err (sticky until reset); an unexpected result is dropped.
- Capture: on i_add_res_valid with a matching tag k, load i_add_result/i_add_flags into buffer k; o_res_valid[k]=1 next cycle.
  - The buffer is guaranteed empty by the credit rule, so a capture never overwrites.
  - End-to-end latency: accept at t -> o_res_valid at t+2+ADD_LAT.
- Drain: o_res_valid[k] && i_res_ready[k] clears o_res_valid[k] and sets credit[k] next cycle.
  - k is eligible again one cycle after the drain, never in the drain cycle itself.
- Hold: buffered result and flags stay stable while o_res_valid=1 and i_res_ready=0.
- Simultaneous events:
  - Capture for k and drain for j≠k in the same cycle: both take effect.
  - Grant and drain in the same cycle for different requesters: both take effect.
- A deasserted i_req_valid without a grant is legal; requests are not sticky.

Decomposition:
- Shared fp_pkg:
  - FP_W=32.
  - Typedef fp_flags_t as a packed struct {ovf, udf, zero}.
  - Typedef add_op_t as a packed struct {a, b, sub}.
- Sub-module rr_arbiter: parameters N; inputs i_clk, i_rst_n, eligible vector, advance strobe; outputs one-hot grant and index.
- The tag pipeline, credit logic and result buffers stay in the top module.

Test Plan:
- Single op, ADD_LAT=3: req0 a=0x3F800000, b=0x40000000, sub=0 at cycle 0.
  - o_add_valid at cycle 1.
  - Bench returns result at cycle 4.
  - o_res_valid[0] at cycle 5 with data 0x40400000, flags 000.
- All four requesters valid continuously, ptr=0, results drained immediately:
  - Grants go 0,1,2,3 on consecutive cycles, then 0 again only after its drain plus one cycle.
  - o_add_valid stays high for 4 cycles.
- Backpressure: req2 computes 0x3F800000-0x3F800000 with i_res_ready[2]=0 for 10 cycles.
  - o_res_data[2]=0x00000000 and flags 001 (zero) are held.
  - req2 re-requests and receives no grant until one cycle after ready rises.
- Error: inject i_add_res_valid=1 with the tag pipeline empty -> o_err=1 from the next cycle and stays 1; no o_res_valid asserts.
- Reset mid-flight: two ops in the adder, assert i_rst_n=0 asynchronously mid-cycle.
  - All outputs go 0 immediately; after release, credits are all 1 and no stale o_res_valid appears.
- Wrap: ptr=3 with only req1 and req3 valid -> grant 3, then 1, then 3 (after its credit returns).

Source files
------------

// File: rtl/fp_pkg.sv
// Shared FP32 types for the adder-sharing controller and its arbiter.
package fp_pkg;

    localparam int FP_W = 32;

    // Adder status bits in the order the adder reports them.
    typedef struct packed {
        logic ovf;
        logic udf;
        logic zero;
    } fp_flags_t;

    // One operation as it is presented to the shared adder.
    typedef struct packed {
        logic [FP_W-1:0] a;
        logic [FP_W-1:0] b;
        logic            sub;
    } add_op_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first eligible index at or after the pointer,
// and moves the pointer just past the winner whenever a grant is taken.
module rr_arbiter
    import fp_pkg::*;
#(
    parameter int N = 4,
    localparam int IW = $clog2(N)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [N-1:0]  i_eligible,
    input  logic          i_advance,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_idx
);

    logic [IW-1:0] ptr_q, ptr_d;
    logic          found;
    int            cand;

    // Walk upward from the pointer with wrap-around; the first eligible index wins.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        found   = 1'b0;
        cand    = 0;
        for (int i = 0; i < N; i++) begin
            cand = int'(ptr_q) + i;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!found && i_eligible[cand]) begin
                found         = 1'b1;
                o_grant[cand] = 1'b1;
                o_idx         = IW'(cand);
            end
        end
    end

    // The next search starts one past the index that was just served.
    always_comb begin
        ptr_d = ptr_q;
        if (i_advance) begin
            ptr_d = (o_idx == IW'(N - 1)) ? '0 : o_idx + IW'(1);
        end
    end

    // Pointer register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/fp_add_share_ctrl.sv
// Shares one fixed-latency FP32 adder among NUM_REQ requesters. Each requester
// holds a single credit, so it has at most one operation in flight and its
// one-entry result buffer is always empty when its result comes back.
module fp_add_share_ctrl
    import fp_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADD_LAT = 3,
    localparam int TAG_W = $clog2(NUM_REQ)
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [NUM_REQ-1:0]      i_req_valid,
    output logic [NUM_REQ-1:0]      o_req_ready,
    input  logic [NUM_REQ*FP_W-1:0] i_req_a,
    input  logic [NUM_REQ*FP_W-1:0] i_req_b,
    input  logic [NUM_REQ-1:0]      i_req_sub,
    output logic                    o_add_valid,
    output logic [FP_W-1:0]         o_add_a,
    output logic [FP_W-1:0]         o_add_b,
    output logic                    o_add_sub,
    input  logic                    i_add_res_valid,
    input  logic [FP_W-1:0]         i_add_result,
    input  logic [2:0]              i_add_flags,
    output logic [NUM_REQ-1:0]      o_res_valid,
    input  logic [NUM_REQ-1:0]      i_res_ready,
    output logic [NUM_REQ*FP_W-1:0] o_res_data,
    output logic [NUM_REQ*3-1:0]    o_res_flags,
    output logic                    o_err
);

    logic [NUM_REQ-1:0] credit_q, credit_d;
    logic [NUM_REQ-1:0] eligible, grant;
    logic [TAG_W-1:0]   grant_idx;
    logic               issue;

    add_op_t            op_q, op_d;
    logic               add_valid_q;
    logic [TAG_W-1:0]   issue_tag_q;

    logic [ADD_LAT-1:0] pipe_vld_q;
    logic [TAG_W-1:0]   pipe_tag_q [ADD_LAT];
    logic               exp_vld;
    logic [TAG_W-1:0]   cap_tag;
    logic               capture, protocol_err;

    logic [NUM_REQ-1:0] res_valid_q, res_valid_d;
    logic [FP_W-1:0]    res_data_q  [NUM_REQ];
    fp_flags_t          res_flags_q [NUM_REQ];
    logic               err_q;

    assign eligible = i_req_valid & credit_q;
    assign issue    = |grant;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_eligible (eligible),
        .i_advance  (issue),
        .o_grant    (grant),
        .o_idx      (grant_idx)
    );

    // Select the winner's operands; without a grant the issue register holds.
    always_comb begin
        op_d = op_q;
        if (issue) begin
            op_d.a   = i_req_a[int'(grant_idx)*FP_W +: FP_W];
            op_d.b   = i_req_b[int'(grant_idx)*FP_W +: FP_W];
            op_d.sub = i_req_sub[grant_idx];
        end
    end

    // Issue register plus the owner tag that travels alongside it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            add_valid_q <= 1'b0;
            issue_tag_q <= '0;
            op_q        <= '0;
        end else begin
            add_valid_q <= issue;
            issue_tag_q <= grant_idx;
            op_q        <= op_d;
        end
    end

    // Tag shift register fed from the issue register; its last stage lines up
    // with the cycle the adder returns that operation's result.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pipe_vld_q <= '0;
            for (int i = 0; i < ADD_LAT; i++) begin
                pipe_tag_q[i] <= '0;
            end
        end else begin
            pipe_vld_q[0] <= add_valid_q;
            pipe_tag_q[0] <= issue_tag_q;
            for (int i = 1; i < ADD_LAT; i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
                pipe_tag_q[i] <= pipe_tag_q[i-1];
            end
        end
    end

    // A result is only accepted when the tag pipe expects one; any disagreement
    // is a protocol error and an unexpected result is simply dropped.
    always_comb begin
        exp_vld      = pipe_vld_q[ADD_LAT-1];
        cap_tag      = pipe_tag_q[ADD_LAT-1];
        capture      = i_add_res_valid && exp_vld;
        protocol_err = i_add_res_valid != exp_vld;
    end

    // Drain returns a credit, a grant consumes one, a capture fills a buffer.
    always_comb begin
        credit_d    = credit_q;
        res_valid_d = res_valid_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (res_valid_q[k] && i_res_ready[k]) begin
                res_valid_d[k] = 1'b0;
                credit_d[k]    = 1'b1;
            end
            if (grant[k]) begin
                credit_d[k] = 1'b0;
            end
            if (capture && cap_tag == TAG_W'(k)) begin
                res_valid_d[k] = 1'b1;
            end
        end
    end

    // Credit, buffer-full and sticky error state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            credit_q    <= '1;
            res_valid_q <= '0;
            err_q       <= 1'b0;
        end else begin
            credit_q    <= credit_d;
            res_valid_q <= res_valid_d;
            if (protocol_err) begin
                err_q <= 1'b1;
            end
        end
    end

    // Result buffers load only on capture, so they hold while waiting for ready.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                res_data_q[k]  <= '0;
                res_flags_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (capture && cap_tag == TAG_W'(k)) begin
                    res_data_q[k]  <= i_add_result;
                    res_flags_q[k] <= fp_flags_t'(i_add_flags);
                end
            end
        end
    end

    // Flatten the per-requester buffers onto the output buses.
    always_comb begin
        o_res_data  = '0;
        o_res_flags = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            o_res_data[k*FP_W +: FP_W] = res_data_q[k];
            o_res_flags[k*3 +: 3]      = res_flags_q[k];
        end
    end

    assign o_req_ready = grant;
    assign o_add_valid = add_valid_q;
    assign o_add_a     = op_q.a;
    assign o_add_b     = op_q.b;
    assign o_add_sub   = op_q.sub;
    assign o_res_valid = res_valid_q;
    assign o_err       = err_q;

endmodule

// File: tb/tb_fp_add_share_ctrl.sv
// Testbench for fp_add_share_ctrl: the bench plays the shared adder and keeps a
// queue-based model of credits, round-robin order and result buffers.
module tb_fp_add_share_ctrl;

    localparam int N   = 4;
    localparam int LAT = 3;

    typedef struct {
        int          owner;
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        int          due;
    } infl_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    reqValid = '0;
    logic [N*32-1:0] reqA = '0;
    logic [N*32-1:0] reqB = '0;
    logic [N-1:0]    reqSub = '0;
    logic [N-1:0]    resReady = '0;
    logic            addResValid = 1'b0;
    logic [31:0]     addResult = '0;
    logic [2:0]      addFlags = '0;

    logic [N-1:0]    o_req_ready;
    logic            o_add_valid;
    logic [31:0]     o_add_a, o_add_b;
    logic            o_add_sub;
    logic [N-1:0]    o_res_valid;
    logic [N*32-1:0] o_res_data;
    logic [N*3-1:0]  o_res_flags;
    logic            o_err;

    int              vectors = 0;
    int              miscompares = 0;
    int              cyc = 0;
    int              stubOwner = -1;
    bit              injectErr = 1'b0;
    logic [N-1:0]    lastGrant;

    bit              mCredit [N];
    int              mPtr;
    logic [N-1:0]    mResValid;
    logic [31:0]     mResData [N];
    logic [2:0]      mResFlags [N];
    logic            mErr, mAddValid, mAddSub;
    logic [31:0]     mAddA, mAddB;
    infl_t           inflight [$];

    fp_add_share_ctrl #(.NUM_REQ(N), .ADD_LAT(LAT)) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_req_valid     (reqValid),
        .o_req_ready     (o_req_ready),
        .i_req_a         (reqA),
        .i_req_b         (reqB),
        .i_req_sub       (reqSub),
        .o_add_valid     (o_add_valid),
        .o_add_a         (o_add_a),
        .o_add_b         (o_add_b),
        .o_add_sub       (o_add_sub),
        .i_add_res_valid (addResValid),
        .i_add_result    (addResult),
        .i_add_flags     (addFlags),
        .o_res_valid     (o_res_valid),
        .i_res_ready     (resReady),
        .o_res_data      (o_res_data),
        .o_res_flags     (o_res_flags),
        .o_err           (o_err)
    );

    // Free-running clock, 10 ns period.
    always #5 clk = ~clk;

    // Stand-in for the adder: exact for the directed operands, a scramble elsewhere.
    function automatic logic [34:0] fakeAdd(logic [31:0] a, logic [31:0] b, logic sub);
        logic [31:0] r;
        if (a == 32'h3F800000 && b == 32'h40000000 && !sub) return {3'b000, 32'h40400000};
        if (sub && a == b) return {3'b001, 32'h00000000};
        r = sub ? a - b : a + b;
        return {r[31] & r[0], r[30] & r[1], r == 32'h0, r};
    endfunction

    function automatic void checkVal(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void modelReset();
        for (int k = 0; k < N; k++) begin
            mCredit[k]   = 1'b1;
            mResData[k]  = '0;
            mResFlags[k] = '0;
        end
        mPtr = 0; mResValid = '0; mErr = 1'b0;
        mAddValid = 1'b0; mAddA = '0; mAddB = '0; mAddSub = 1'b0;
        inflight.delete();
    endfunction

    task automatic setOp(int k, logic [31:0] a, logic [31:0] b, logic sub);
        reqA[k*32 +: 32] = a;
        reqB[k*32 +: 32] = b;
        reqSub[k]        = sub;
    endtask

    task automatic checkOutput();
        checkVal("add_valid", 32'(o_add_valid), 32'(mAddValid));
        checkVal("add_a", o_add_a, mAddA);
        checkVal("add_b", o_add_b, mAddB);
        checkVal("add_sub", 32'(o_add_sub), 32'(mAddSub));
        checkVal("res_valid", 32'(o_res_valid), 32'(mResValid));
        for (int k = 0; k < N; k++) begin
            checkVal($sformatf("res_data%0d", k), o_res_data[k*32 +: 32], mResData[k]);
            checkVal($sformatf("res_flags%0d", k), 32'(o_res_flags[k*3 +: 3]), 32'(mResFlags[k]));
        end
        checkVal("err", 32'(o_err), 32'(mErr));
    endtask

    // Drives the adder's return path from the in-flight queue (or a stray strobe).
    task automatic applyStimulus();
        stubOwner = -1; addResValid = 1'b0; addResult = '0; addFlags = '0;
        if (inflight.size() > 0 && inflight[0].due == cyc) begin
            infl_t e;
            e = inflight.pop_front();
            {addFlags, addResult} = fakeAdd(e.a, e.b, e.sub);
            addResValid = 1'b1;
            stubOwner = e.owner;
        end else if (injectErr) begin
            addResValid = 1'b1;
            addResult = 32'hDEADBEEF;
            addFlags = 3'b100;
        end
    endtask

    // One clock: check state, drive inputs, check grant, advance model and DUT.
    task automatic runCycle();
        int k;
        bit found;
        logic [N-1:0] expGrant;
        checkOutput();
        applyStimulus();
        #1;
        expGrant = '0; found = 1'b0; k = 0;
        for (int i = 0; i < N; i++) begin
            int j;
            j = (mPtr + i) % N;
            if (!found && reqValid[j] && mCredit[j]) begin
                found = 1'b1;
                k = j;
            end
        end
        if (found) expGrant[k] = 1'b1;
        checkVal("req_ready", 32'(o_req_ready), 32'(expGrant));
        lastGrant = o_req_ready;
        for (int i = 0; i < N; i++) begin
            if (mResValid[i] && resReady[i]) begin
                mResValid[i] = 1'b0;
                mCredit[i] = 1'b1;
            end
        end
        if (stubOwner >= 0) begin
            mResValid[stubOwner] = 1'b1;
            mResData[stubOwner]  = addResult;
            mResFlags[stubOwner] = addFlags;
        end else if (addResValid) begin
            mErr = 1'b1;
        end
        if (found) begin
            mCredit[k] = 1'b0;
            mPtr = (k + 1) % N;
            mAddValid = 1'b1;
            mAddA = reqA[k*32 +: 32];
            mAddB = reqB[k*32 +: 32];
            mAddSub = reqSub[k];
            inflight.push_back('{owner: k, a: mAddA, b: mAddB, sub: mAddSub, due: cyc + 1 + LAT});
        end else begin
            mAddValid = 1'b0;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Asserts reset mid-cycle, checks registered outputs clear at once, releases.
    task automatic doReset();
        reqValid = '0; resReady = '0; addResValid = 1'b0; injectErr = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        checkVal("rst_add_valid", 32'(o_add_valid), 32'h0);
        checkVal("rst_add_a", o_add_a, 32'h0);
        checkVal("rst_add_b", o_add_b, 32'h0);
        checkVal("rst_add_sub", 32'(o_add_sub), 32'h0);
        checkVal("rst_res_valid", 32'(o_res_valid), 32'h0);
        for (int k = 0; k < N; k++) begin
            checkVal("rst_res_data", o_res_data[k*32 +: 32], 32'h0);
            checkVal("rst_res_flags", 32'(o_res_flags[k*3 +: 3]), 32'h0);
        end
        checkVal("rst_err", 32'(o_err), 32'h0);
        modelReset();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    // Directed scenarios first, then randomized traffic, error and reset cases.
    initial begin
        logic [N-1:0] expG  [8];
        logic         expAv [8];
        logic [N-1:0] wrapG [3];
        int           nw;

        modelReset();
        #1;
        doReset();

        // Single op: 1.0 + 2.0 from requester 0.
        reqValid = 4'b0001; setOp(0, 32'h3F800000, 32'h40000000, 1'b0); resReady = '1;
        runCycle();
        reqValid = '0;
        checkVal("single_add_valid", 32'(o_add_valid), 32'h1);
        checkVal("single_add_a", o_add_a, 32'h3F800000);
        repeat (4) runCycle();
        checkVal("single_res_valid", 32'(o_res_valid), 32'h1);
        checkVal("single_res_data", o_res_data[31:0], 32'h40400000);
        checkVal("single_res_flags", 32'(o_res_flags[2:0]), 32'h0);
        repeat (2) runCycle();

        // All requesters hammering, results drained immediately.
        doReset();
        expG  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0000, 4'b0001, 4'b0010};
        expAv = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        reqValid = '1; resReady = '1;
        for (int k = 0; k < N; k++) setOp(k, $urandom, $urandom, 1'($urandom));
        for (int c = 0; c < 8; c++) begin
            runCycle();
            checkVal($sformatf("all4_grant%0d", c), 32'(lastGrant), 32'(expG[c]));
            checkVal($sformatf("all4_add_valid%0d", c + 1), 32'(o_add_valid), 32'(expAv[c]));
        end
        reqValid = '0;
        repeat (10) runCycle();

        // Backpressure on requester 2 with a zero result, then wrap-around.
        doReset();
        reqValid = 4'b0100; setOp(2, 32'h3F800000, 32'h3F800000, 1'b1); resReady = 4'b1011;
        for (int c = 0; c < 15; c++) begin
            runCycle();
            checkVal($sformatf("bp_grant%0d", c), 32'(lastGrant), (c == 0) ? 32'h4 : 32'h0);
            if (c + 1 >= 5) begin
                checkVal("bp_res_valid2", 32'(o_res_valid[2]), 32'h1);
                checkVal("bp_res_data2", o_res_data[95:64], 32'h0);
                checkVal("bp_res_flags2", 32'(o_res_flags[8:6]), 32'h1);
            end
        end
        resReady = '1;
        runCycle();
        checkVal("bp_drain_cycle_grant", 32'(lastGrant), 32'h0);
        runCycle();
        checkVal("bp_regrant", 32'(lastGrant), 32'h4);
        reqValid = 4'b1010;
        setOp(1, $urandom, $urandom, 1'b0); setOp(3, $urandom, $urandom, 1'b1);
        wrapG = '{default: '0};
        nw = 0;
        for (int c = 0; c < 12; c++) begin
            runCycle();
            if (lastGrant != '0 && nw < 3) begin
                wrapG[nw] = lastGrant;
                nw++;
            end
        end
        checkVal("wrap_grant0", 32'(wrapG[0]), 32'h8);
        checkVal("wrap_grant1", 32'(wrapG[1]), 32'h2);
        checkVal("wrap_grant2", 32'(wrapG[2]), 32'h8);
        reqValid = '0;

        // Randomized traffic with random backpressure.
        for (int c = 0; c < 400; c++) begin
            reqValid = N'($urandom);
            for (int k = 0; k < N; k++) begin
                setOp(k, $urandom, $urandom, 1'($urandom));
                resReady[k] = ($urandom_range(3) != 0);
            end
            runCycle();
        end

        // Quiesce, then a stray adder strobe must raise the sticky error.
        reqValid = '0; resReady = '1;
        for (int c = 0; c < 30 && (inflight.size() != 0 || mResValid != '0); c++) runCycle();
        checkVal("idle_bound", 32'(inflight.size()), 32'h0);
        runCycle();
        injectErr = 1'b1;
        runCycle();
        injectErr = 1'b0;
        for (int c = 0; c < 4; c++) begin
            checkVal("err_sticky", 32'(o_err), 32'h1);
            checkVal("err_no_res", 32'(o_res_valid), 32'h0);
            runCycle();
        end

        // Reset with two operations inside the adder.
        reqValid = 4'b0011;
        setOp(0, $urandom, $urandom, 1'b0); setOp(1, $urandom, $urandom, 1'b1);
        runCycle();
        runCycle();
        reqValid = '0;
        doReset();
        resReady = '1;
        for (int c = 0; c < 10; c++) begin
            runCycle();
            checkVal("post_rst_no_res", 32'(o_res_valid), 32'h0);
        end
        reqValid = '1;
        runCycle();
        checkVal("post_rst_grant", 32'(lastGrant), 32'h1);
        for (int c = 0; c < 60; c++) begin
            reqValid = N'($urandom);
            for (int k = 0; k < N; k++) setOp(k, $urandom, $urandom, 1'($urandom));
            runCycle();
        end
        reqValid = '0;
        repeat (12) runCycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
